alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 166 ++++++++++++++++
 tb/tb_alu_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 registers the request, S2 holds the result, flags and tag.
// Define ALU_PIPE_FLAGS_EN to enable the carry/overflow/negative flags; otherwise they read 0.
module alu_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] dataA_i,
  input  logic [DATA_W-1:0] dataB_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic              Zero_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              carry_o,
  output logic              overflow_o,
  output logic              negative_o
);

  localparam int unsigned ShW = $clog2(DATA_W);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpSll = 3'b100;
  localparam logic [2:0] OpSrl = 3'b101;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  logic              s1_valid_d, s1_valid_q;
  logic [DATA_W-1:0] a_d, a_q, b_d, b_q;
  logic [2:0]        op_d, op_q;
  logic [TAG_W-1:0]  tag1_d, tag1_q;

  logic              s2_valid_d, s2_valid_q;
  logic [DATA_W-1:0] res_d, res_q;
  logic [TAG_W-1:0]  tag2_d, tag2_q;

  logic              s1_adv, accept, s2_load;
  logic [DATA_W-1:0] alu_res;

  // S1 may move forward whenever S2 is empty or being drained this cycle.
  assign s1_adv     = !s2_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s1_adv;
  assign accept     = in_valid_i && in_ready_o;
  assign s2_load    = s1_adv && s1_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tag1_d     = tag1_q;
    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
    end
    if (accept) begin
      a_d    = dataA_i;
      b_d    = dataB_i;
      op_d   = ALUCtrl_i;
      tag1_d = tag_i;
    end
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpAdd: alu_res = a_q + b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpSll: alu_res = a_q << b_q[ShW-1:0];
      OpSrl: alu_res = a_q >> b_q[ShW-1:0];
      OpSub: alu_res = a_q - b_q;
      OpSlt: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    tag2_d     = tag2_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      res_d  = alu_res;
      tag2_d = tag1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tag1_q     <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      tag2_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tag1_q     <= tag1_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      tag2_q     <= tag2_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign ALUResult_o = res_q;
  assign Zero_o      = (res_q == '0);
  assign tag_o       = tag2_q;

`ifdef ALU_PIPE_FLAGS_EN
  logic carry_d, carry_q, ovf_d, ovf_q;
  logic b_msb, cin_msb;

  always_comb begin
    // MSB full-adder slice recovers carry-in/out of the top bit without a wider adder.
    b_msb   = (op_q == OpSub) ? ~b_q[DATA_W-1] : b_q[DATA_W-1];
    cin_msb = alu_res[DATA_W-1] ^ a_q[DATA_W-1] ^ b_msb;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (s2_load) begin
      if (op_q == OpAdd || op_q == OpSub) begin
        carry_d = (a_q[DATA_W-1] & b_msb) | (cin_msb & (a_q[DATA_W-1] ^ b_msb));
        ovf_d   = carry_d ^ cin_msb;
      end else begin
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry_o    = carry_q;
  assign overflow_o = ovf_q;
  assign negative_o = res_q[DATA_W-1];
`else
  assign carry_o    = 1'b0;
  assign overflow_o = 1'b0;
  assign negative_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases, back-pressure, mid-flight reset and
// randomized traffic checked against an arithmetic reference model and an in-order queue.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
`ifdef ALU_PIPE_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic [2:0]    op;
  logic [TW-1:0] tag;
  logic          out_valid, out_ready;
  logic [W-1:0]  res;
  logic          zero;
  logic [TW-1:0] tag_out;
  logic          cf, vf, nf;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_W(W), .TAG_W(TW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .dataA_i    (a),
    .dataB_i    (b),
    .ALUCtrl_i  (op),
    .tag_i      (tag),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .ALUResult_o(res),
    .Zero_o     (zero),
    .tag_o      (tag_out),
    .carry_o    (cf),
    .overflow_o (vf),
    .negative_o (nf)
  );

  typedef struct packed {
    logic [W-1:0]  res;
    logic          z, c, v, n;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [2:0] f, input logic [TW-1:0] t);
    exp_t e;
    longint unsigned ux, uy, modv, full;
    longint sx, sy, s, smax, smin;
    int sh;
    bit c, v;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    modv = longint'(1) << W;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    sh = int'(uy % W);
    c = 1'b0; v = 1'b0;
    e = '0;
    case (f)
      3'd0: e.res = x & y;
      3'd1: e.res = x | y;
      3'd2: begin
        full  = ux + uy;
        e.res = W'(full % modv);
        c     = full >= modv;
        s     = sx + sy;
        v     = (s > smax) || (s < smin);
      end
      3'd3: e.res = x ^ y;
      3'd4: e.res = x << sh;
      3'd5: e.res = x >> sh;
      3'd6: begin
        e.res = W'((ux + modv - uy) % modv);
        c     = ux >= uy;
        s     = sx - sy;
        v     = (s > smax) || (s < smin);
      end
      default: e.res = (sx < sy) ? W'(1) : W'(0);
    endcase
    e.z   = (e.res == 0);
    e.c   = FlagsOn && c;
    e.v   = FlagsOn && v;
    e.n   = FlagsOn && e.res[W-1];
    e.tag = t;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: sample away from the edge, score outputs, record acceptance, advance to negedge.
  task automatic step(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    if (out_valid) begin
      chk("out_has_pending", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q[0];
        chk("res", res, e.res);
        chk("zero", zero, e.z);
        chk("tag", tag_out, e.tag);
        chk("carry", cf, e.c);
        chk("ovf", vf, e.v);
        chk("neg", nf, e.n);
        if (out_ready) void'(q.pop_front());
      end
    end
    if (acc) q.push_back(model(a, b, op, tag));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_res"}, res, 0);
    chk({name, "_zero"}, zero, 1);
    chk({name, "_tag"}, tag_out, 0);
    chk({name, "_c"}, cf, 0);
    chk({name, "_v"}, vf, 0);
    chk({name, "_n"}, nf, 0);
    chk({name, "_ready"}, in_ready, 1);
  endtask

  task automatic dir(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] f,
                     input logic [TW-1:0] t, input logic [W-1:0] er,
                     input bit ec, input bit ev, input bit en);
    bit acc;
    in_valid = 1'b1; a = x; b = y; op = f; tag = t; out_ready = 1'b1;
    step(acc);
    chk("dir_accept", acc, 1);
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    chk("dir_lat1", out_valid, 0);
    step(acc);
    chk("dir_lat2", out_valid, 1);
    chk("dir_res", res, er);
    chk("dir_zero", zero, er == 0);
    chk("dir_tag", tag_out, t);
    chk("dir_c", cf, FlagsOn && ec);
    chk("dir_v", vf, FlagsOn && ev);
    chk("dir_n", nf, FlagsOn && en);
    step(acc);
  endtask

  task automatic drain(input string name);
    bit acc;
    int guard;
    in_valid = 1'b0; out_ready = 1'b1; guard = 0;
    while (q.size() != 0 && guard < 20) begin
      step(acc);
      guard++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int n_acc, cyc;
    bit saw_low;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; tag = '0; out_ready = 1'b1;
    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    dir(32'hFFFF_FFFF, 32'h1,        3'b010, 4'd3, 32'h0,        1, 0, 0);
    dir(32'h8000_0000, 32'h1,        3'b110, 4'd5, 32'h7FFF_FFFF, 1, 1, 0);
    dir(32'hFFFF_FFFF, 32'h1,        3'b111, 4'd6, 32'h1,        0, 0, 0);
    dir(32'h1,         32'h25,       3'b100, 4'd7, 32'h20,       0, 0, 0);
    dir(32'h8000_0000, 32'd31,       3'b101, 4'd8, 32'h1,        0, 0, 0);
    dir(32'h7FFF_FFFF, 32'h1,        3'b010, 4'd9, 32'h8000_0000, 0, 1, 1);
    dir(32'h5,         32'h7,        3'b110, 4'hA, 32'hFFFF_FFFE, 0, 0, 1);
    dir(32'hA5A5_A5A5, 32'hFFFF_FFFF, 3'b011, 4'hB, 32'h5A5A_5A5A, 0, 0, 0);
    dir(32'h8000_0000, 32'h1,        3'b001, 4'hC, 32'h8000_0001, 0, 0, 1);
    dir(32'h0000_F0F0, 32'h0000_0F0F, 3'b000, 4'hD, 32'h0,        0, 0, 0);

    // Back-to-back stream with a three-cycle consumer stall in the middle.
    n_acc = 0; cyc = 0; saw_low = 1'b0;
    while (n_acc < 8 && cyc < 40) begin
      in_valid = 1'b1; a = pick(); b = pick(); op = 3'($urandom_range(0, 7));
      tag = n_acc[TW-1:0];
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (!in_ready) saw_low = 1'b1;
      step(acc);
      if (cyc < 3) chk("stream_accept", acc, 1);
      if (acc) n_acc++;
      cyc++;
    end
    chk("stream_count", n_acc, 8);
    chk("stall_ready_low", saw_low, 1);
    drain("stream_drain");

    // Reset with two requests in flight.
    in_valid = 1'b1; a = 32'h10; b = 32'h20; op = 3'b010; tag = 4'h1;
    step(acc);
    a = 32'h30; tag = 4'h2;
    step(acc);
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      step(acc);
      chk("post_rst_valid", out_valid, 0);
    end

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = pick();
      b         = pick();
      op        = 3'($urandom_range(0, 7));
      tag       = TW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      step(acc);
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
